popcount_seq: RTL and testbench

Sequential, parametrised population counter for W-bit words with a valid/ready handshake on both sides. It counts CHUNK bits per clock, and a mode bit selects whether it counts ones or zeros. A saturating running total can accumulate counts across consecutive words. It sits between a word producer and any consumer that needs bit statistics, and replaces single-cycle combinational counters where W is large.

---
 rtl/popcount_seq.sv | 141 ++++++++++++++
 tb/tb_popcount_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_seq.sv
// rtl/popcount_seq.sv - sequential chunked population counter with saturating running total
//
// Counts ones (in_mode_i=0) or zeros (in_mode_i=1) of a W-bit word, CHUNK bits per clock.
// Ports:
//   clk_i, reset_i       clock, asynchronous active-high reset
//   in_valid_i/in_ready_o, in_data_i, in_mode_i, in_acc_i   word input handshake
//   out_valid_o/out_ready_i, out_count_o                    per-word result handshake
//   total_o              saturating running total, clr_i clears it synchronously
module popcount_seq #(
    parameter int W     = 32,
    parameter int CHUNK = 8,
    parameter int TOTW  = 16,
    localparam int N    = W / CHUNK,
    localparam int CW   = $clog2(W + 1)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [W-1:0]    in_data_i,
    input  logic            in_mode_i,
    input  logic            in_acc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [CW-1:0]   out_count_o,
    output logic [TOTW-1:0] total_o,
    input  logic            clr_i
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [W-1:0]      data_q;
    logic              mode_q;
    logic              acc_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic [CW-1:0]     out_count_q;
    logic [TOTW-1:0]   total_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [CHUNK-1:0]  chunk_d;
    logic [CW-1:0]     cnt_d;
    logic [TOTW:0]     tot_sum_d;
    logic [TOTW-1:0]   total_d;

    function automatic logic [CW-1:0] chunk_ones(input logic [CHUNK-1:0] c);
        logic [CW-1:0] s;
        s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s = s + CW'(c[i]);
        end
        return s;
    endfunction

    // The word is shifted right each COUNT cycle, so the current chunk is
    // always the low CHUNK bits; XOR with the mode bit turns a zero count
    // into a ones count.
    always_comb begin
        chunk_d   = data_q[CHUNK-1:0] ^ {CHUNK{mode_q}};
        cnt_d     = cnt_q + chunk_ones(chunk_d);
        tot_sum_d = {1'b0, total_q} + (TOTW + 1)'(cnt_q);
        total_d   = TOTW'(cnt_q);
        if (acc_q) begin
            total_d = tot_sum_d[TOTW] ? {TOTW{1'b1}} : tot_sum_d[TOTW-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            mode_q      <= 1'b0;
            acc_q       <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            out_count_q <= '0;
            total_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        data_q     <= in_data_i;
                        mode_q     <= in_mode_i;
                        acc_q      <= in_acc_i;
                        cnt_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    cnt_q  <= cnt_d;
                    data_q <= data_q >> CHUNK;
                    idx_q  <= idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        out_count_q <= cnt_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        total_q     <= total_d;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
            // Clear wins over a coincident result handshake.
            if (clr_i) begin
                total_q <= '0;
            end
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_count_o = out_count_q;
    assign total_o     = total_q;

    cfg_check: assert property (@(posedge clk_i) (W % CHUNK == 0) && (TOTW >= CW))
        else $error("popcount_seq: W must be a multiple of CHUNK and TOTW >= CW");

endmodule

// File: tb/tb_popcount_seq.sv
// tb/tb_popcount_seq.sv - directed scoreboard bench for popcount_seq (three configurations)
module tb_popcount_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Index 0: W32/C8/T16, 1: W32/C8/T6 (saturation), 2: W6/C6/T8.
    logic        in_valid [3];
    logic        in_mode  [3];
    logic        in_acc   [3];
    logic        out_ready[3];
    logic        clr      [3];
    logic [31:0] in_data  [3];

    logic        a_rdy, a_vld, s_rdy, s_vld, b_rdy, b_vld;
    logic [5:0]  a_cnt, s_cnt;
    logic [2:0]  b_cnt;
    logic [15:0] a_tot;
    logic [5:0]  s_tot;
    logic [7:0]  b_tot;

    logic        in_ready_w [3];
    logic        out_valid_w[3];
    logic [31:0] cnt_w      [3];
    logic [31:0] tot_w      [3];

    popcount_seq #(.W(32), .CHUNK(8), .TOTW(16)) u_a (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid[0]), .in_ready_o(a_rdy),
        .in_data_i(in_data[0]), .in_mode_i(in_mode[0]), .in_acc_i(in_acc[0]),
        .out_valid_o(a_vld), .out_ready_i(out_ready[0]), .out_count_o(a_cnt),
        .total_o(a_tot), .clr_i(clr[0]));

    popcount_seq #(.W(32), .CHUNK(8), .TOTW(6)) u_s (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid[1]), .in_ready_o(s_rdy),
        .in_data_i(in_data[1]), .in_mode_i(in_mode[1]), .in_acc_i(in_acc[1]),
        .out_valid_o(s_vld), .out_ready_i(out_ready[1]), .out_count_o(s_cnt),
        .total_o(s_tot), .clr_i(clr[1]));

    popcount_seq #(.W(6), .CHUNK(6), .TOTW(8)) u_b (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid[2]), .in_ready_o(b_rdy),
        .in_data_i(in_data[2][5:0]), .in_mode_i(in_mode[2]), .in_acc_i(in_acc[2]),
        .out_valid_o(b_vld), .out_ready_i(out_ready[2]), .out_count_o(b_cnt),
        .total_o(b_tot), .clr_i(clr[2]));

    always_comb begin
        in_ready_w[0] = a_rdy;  out_valid_w[0] = a_vld;  cnt_w[0] = 32'(a_cnt);  tot_w[0] = 32'(a_tot);
        in_ready_w[1] = s_rdy;  out_valid_w[1] = s_vld;  cnt_w[1] = 32'(s_cnt);  tot_w[1] = 32'(s_tot);
        in_ready_w[2] = b_rdy;  out_valid_w[2] = b_vld;  cnt_w[2] = 32'(b_cnt);  tot_w[2] = 32'(b_tot);
    end

    int checks   = 0;
    int failures = 0;

    int width  [3] = '{32, 32, 6};
    int nchunk [3] = '{4, 4, 1};
    int totmax [3] = '{65535, 63, 255};
    int tot_m  [3] = '{0, 0, 0};
    logic acc_m[3];
    int sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_count(input logic [31:0] d, input logic m, input int w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return $countones((m ? ~d : d) & mask);
    endfunction

    // Present a word in IDLE and accept it on the next edge; expected count goes to the scoreboard.
    task automatic send(input int u, input logic [31:0] d, input logic m, input logic a);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready_w[u]), 32'd1);
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        in_mode[u]  = m;
        in_acc[u]   = a;
        acc_m[u]    = a;
        sb_q.push_back(model_count(d, m, width[u]));
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
    endtask

    // out_valid must rise exactly N edges after the accept edge, in_ready low throughout.
    task automatic wait_out(input int u);
        for (int k = 0; k <= nchunk[u]; k++) begin
            @(negedge clk);
            check("in_ready_busy", 32'(in_ready_w[u]), 32'd0);
            check("out_valid_latency", 32'(out_valid_w[u]), 32'(k == nchunk[u]));
        end
    endtask

    // Complete the output handshake, optionally with a coincident clear.
    task automatic recv(input int u, input logic c);
        int exp_cnt;
        exp_cnt = -1;
        @(negedge clk);
        check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) exp_cnt = sb_q.pop_front();
        check("out_count", cnt_w[u], 32'(exp_cnt));
        out_ready[u] = 1'b1;
        clr[u]       = c;
        @(posedge clk);
        #1;
        out_ready[u] = 1'b0;
        clr[u]       = 1'b0;
        if (c) tot_m[u] = 0;
        else if (acc_m[u]) tot_m[u] = (tot_m[u] + exp_cnt > totmax[u]) ? totmax[u] : tot_m[u] + exp_cnt;
        else tot_m[u] = exp_cnt;
        @(negedge clk);
        check("out_valid_after_hs", 32'(out_valid_w[u]), 32'd0);
        check("in_ready_after_hs", 32'(in_ready_w[u]), 32'd1);
        check("total", tot_w[u], 32'(tot_m[u]));
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0; in_mode[u] = 1'b0; in_acc[u] = 1'b0;
            out_ready[u] = 1'b0; clr[u] = 1'b0; in_data[u] = '0; acc_m[u] = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check("rst_in_ready", 32'(in_ready_w[u]), 32'd1);
            check("rst_out_valid", 32'(out_valid_w[u]), 32'd0);
            check("rst_out_count", cnt_w[u], 32'd0);
            check("rst_total", tot_w[u], 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // All ones, count ones.
        send(0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_out(0);
        recv(0, 1'b0);

        // Count zeros, restart total.
        send(0, 32'h0000_000F, 1'b1, 1'b0);
        wait_out(0);
        recv(0, 1'b0);

        // Backpressure with input activity in DONE.
        send(0, 32'hA5A5_0F0F, 1'b0, 1'b1);
        wait_out(0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid[0] = (i % 2 == 0);
            in_data[0]  = $urandom;
            in_mode[0]  = 1'(i % 3 == 0);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid_w[0]), 32'd1);
            check("bp_in_ready", 32'(in_ready_w[0]), 32'd0);
            check("bp_out_count", cnt_w[0], 32'(sb_q[0]));
        end
        in_valid[0] = 1'b0;
        recv(0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("bp_no_second", 32'(out_valid_w[0]), 32'd0);
        end

        // Reset during COUNT cycle 2.
        send(0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        void'(sb_q.pop_back());
        tot_m[0] = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("midrst_out_valid", 32'(out_valid_w[0]), 32'd0);
            check("midrst_in_ready", 32'(in_ready_w[0]), 32'd1);
        end
        check("midrst_total", tot_w[0], 32'd0);
        send(0, 32'h0000_0001, 1'b0, 1'b1);
        wait_out(0);
        recv(0, 1'b0);

        // Saturation at TOTW=6, then clear coincident with a handshake.
        send(1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_out(1);
        recv(1, 1'b0);
        send(1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_out(1);
        recv(1, 1'b0);
        send(1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_out(1);
        recv(1, 1'b1);

        // Single-chunk configuration.
        send(2, 32'h0000_002D, 1'b0, 1'b0);
        wait_out(2);
        recv(2, 1'b0);
        send(2, 32'h0000_002D, 1'b1, 1'b1);
        wait_out(2);
        recv(2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
